// File: rtl/can_pkg.sv
// Shared types for the CAN transmit scheduler: frame record, FSM states, DLC limit.
package can_pkg;

  localparam logic [3:0] CAN_MAX_DLC = 4'd8;

  typedef struct packed {
    logic [10:0] id;
    logic [3:0]  len;
    logic [63:0] data;
  } can_frame_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OFFER,
    ST_WAIT
  } sched_state_t;

  // DLC codes above 8 still carry 8 data bytes on a classic CAN bus
  function automatic logic [3:0] sat_dlc(input logic [3:0] len);
    return (len > CAN_MAX_DLC) ? CAN_MAX_DLC : len;
  endfunction

endpackage

// File: rtl/can_prio_select.sv
// Combinational priority picker: lowest identifier among pending mailboxes,
// ties resolved to the lower mailbox index.
module can_prio_select
  import can_pkg::*;
#(
  parameter int unsigned NUM_MB = 4,
  localparam int unsigned IDX_W = $clog2(NUM_MB)
) (
  input  logic [NUM_MB-1:0] i_pend,
  input  logic [10:0]       i_ids [NUM_MB],
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_valid
);

  localparam int unsigned N2    = 1 << IDX_W;
  localparam int unsigned NODES = 2 * N2 - 1;

  logic             w_v  [NODES];
  logic [10:0]      w_id [NODES];
  logic [IDX_W-1:0] w_ix [NODES];

  // Heap-ordered min tree: leaves at N2-1+i, node k has children 2k+1 (lower
  // indices) and 2k+2; nodes are resolved from the bottom up.
  always_comb begin
    int unsigned k;
    int unsigned l;
    int unsigned r;
    for (int unsigned n = 0; n < NODES; n++) begin
      w_v[n]  = 1'b0;
      w_id[n] = '0;
      w_ix[n] = '0;
    end
    for (int unsigned i = 0; i < NUM_MB; i++) begin
      w_v[N2-1+i]  = i_pend[i];
      w_id[N2-1+i] = i_ids[i];
      w_ix[N2-1+i] = IDX_W'(i);
    end
    for (int unsigned j = 0; j < N2 - 1; j++) begin
      k = N2 - 2 - j;
      l = 2 * k + 1;
      r = 2 * k + 2;
      w_v[k] = w_v[l] | w_v[r];
      if (w_v[l] && (!w_v[r] || (w_id[l] <= w_id[r]))) begin
        w_id[k] = w_id[l];
        w_ix[k] = w_ix[l];
      end else begin
        w_id[k] = w_id[r];
        w_ix[k] = w_ix[r];
      end
    end
    o_valid = w_v[0];
    o_idx   = w_ix[0];
  end

endmodule

// File: rtl/can_tx_sched.sv
// CAN transmit scheduler: NUM_MB mailboxes, lowest-ID-first offer to the
// frame transmitter, requeue on arbitration loss, bounded error retries.
// Optional per-mailbox abort is built when CAN_TX_SCHED_ABORT_EN is defined.
module can_tx_sched
  import can_pkg::*;
#(
  parameter int unsigned NUM_MB    = 4,
  parameter int unsigned MAX_RETRY = 8,
  localparam int unsigned IDX_W    = $clog2(NUM_MB)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_mb,
  input  logic [10:0]       wr_id,
  input  logic [3:0]        wr_len,
  input  logic [63:0]       wr_data,
  output logic              wr_err,
  output logic [NUM_MB-1:0] mb_pending,
`ifdef CAN_TX_SCHED_ABORT_EN
  input  logic [NUM_MB-1:0] abort,
`endif
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [10:0]       tx_id,
  output logic [3:0]        tx_len,
  output logic [63:0]       tx_data,
  input  logic              tx_done,
  input  logic              tx_ok,
  input  logic              tx_arblost,
  output logic              done_valid,
  output logic [IDX_W-1:0]  done_mb,
  output logic              done_ok
);

  localparam logic [7:0] RETRY_LIM = 8'(MAX_RETRY);

  sched_state_t      r_state;
  can_frame_t        r_frame [NUM_MB];
  logic [NUM_MB-1:0] r_pend;
  logic [7:0]        r_retry [NUM_MB];
  logic [IDX_W-1:0]  r_cur;
  can_frame_t        r_tx;
  logic              r_tx_valid;
  logic              r_wr_err;
  logic              r_done_valid;
  logic              r_done_ok;
  logic [IDX_W-1:0]  r_done_mb;

  logic [10:0]       w_ids [NUM_MB];
  logic [IDX_W-1:0]  w_sel_idx;
  logic              w_sel_valid;
  logic              w_wr_inrange;
  logic              w_wr_accept;
  logic              w_wr_reject;
  can_frame_t        w_wr_frame;
  logic [7:0]        w_retry_nx;
  logic              w_retry_lim;
  logic              w_cur_abort;

  // Identifier view of the mailbox array for the selector
  always_comb begin
    for (int unsigned i = 0; i < NUM_MB; i++) begin
      w_ids[i] = r_frame[i].id;
    end
  end

  can_prio_select #(
    .NUM_MB (NUM_MB)
  ) u_sel (
    .i_pend  (r_pend),
    .i_ids   (w_ids),
    .o_idx   (w_sel_idx),
    .o_valid (w_sel_valid)
  );

  assign w_wr_inrange = (32'(wr_mb) < NUM_MB);
  assign w_wr_accept  = wr_en && w_wr_inrange && !r_pend[wr_mb];
  assign w_wr_reject  = wr_en && w_wr_inrange &&  r_pend[wr_mb];
  assign w_wr_frame   = '{id: wr_id, len: sat_dlc(wr_len), data: wr_data};
  assign w_retry_nx   = r_retry[r_cur] + 8'd1;
  assign w_retry_lim  = (w_retry_nx == RETRY_LIM);

`ifdef CAN_TX_SCHED_ABORT_EN
  logic [NUM_MB-1:0] r_abort;
  logic [NUM_MB-1:0] r_abort_d;
  logic              w_abort_any;
  logic [IDX_W-1:0]  w_abort_idx;
  logic [NUM_MB-1:0] w_abort_clr;

  assign w_cur_abort = r_abort[r_cur];

  // Lowest-indexed flagged mailbox, and the flags to drop this cycle: every
  // path that clears a pending bit must also clear its abort flag.
  always_comb begin
    w_abort_any = 1'b0;
    w_abort_idx = '0;
    w_abort_clr = '0;
    for (int unsigned i = 0; i < NUM_MB; i++) begin
      if (r_abort[i] && !w_abort_any) begin
        w_abort_any = 1'b1;
        w_abort_idx = IDX_W'(i);
      end
    end
    if (r_state == ST_IDLE && w_abort_any) begin
      w_abort_clr[w_abort_idx] = 1'b1;
    end
    if (r_state == ST_WAIT && tx_done &&
        (tx_ok || w_cur_abort || (!tx_arblost && w_retry_lim))) begin
      w_abort_clr[r_cur] = 1'b1;
    end
  end

  // Sticky abort flags, set on a rising request against a pending mailbox
  always_ff @(posedge clk) begin
    if (rst) begin
      r_abort   <= '0;
      r_abort_d <= '0;
    end else begin
      r_abort_d <= abort;
      r_abort   <= (r_abort | (abort & ~r_abort_d & r_pend)) & ~w_abort_clr;
    end
  end
`else
  assign w_cur_abort = 1'b0;
`endif

  // Scheduler FSM, mailbox store and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_pend       <= '0;
      r_cur        <= '0;
      r_tx         <= '0;
      r_tx_valid   <= 1'b0;
      r_wr_err     <= 1'b0;
      r_done_valid <= 1'b0;
      r_done_ok    <= 1'b0;
      r_done_mb    <= '0;
      for (int unsigned i = 0; i < NUM_MB; i++) begin
        r_retry[i] <= '0;
      end
    end else begin
      r_done_valid <= 1'b0;
      r_wr_err     <= w_wr_reject;

      if (w_wr_accept) begin
        r_frame[wr_mb] <= w_wr_frame;
        r_retry[wr_mb] <= '0;
        r_pend[wr_mb]  <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
`ifdef CAN_TX_SCHED_ABORT_EN
          if (w_abort_any) begin
            r_pend[w_abort_idx] <= 1'b0;
            r_done_valid        <= 1'b1;
            r_done_mb           <= w_abort_idx;
            r_done_ok           <= 1'b0;
          end else
`endif
          if (w_sel_valid) begin
            r_tx       <= r_frame[w_sel_idx];
            r_cur      <= w_sel_idx;
            r_tx_valid <= 1'b1;
            r_state    <= ST_OFFER;
          end
        end

        ST_OFFER: begin
          if (tx_ready) begin
            r_tx_valid <= 1'b0;
            r_state    <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (tx_done) begin
            r_state <= ST_IDLE;
            if (tx_ok) begin
              r_pend[r_cur]  <= 1'b0;
              r_retry[r_cur] <= '0;
              r_done_valid   <= 1'b1;
              r_done_mb      <= r_cur;
              r_done_ok      <= 1'b1;
            end else if (w_cur_abort) begin
              r_pend[r_cur] <= 1'b0;
              r_done_valid  <= 1'b1;
              r_done_mb     <= r_cur;
              r_done_ok     <= 1'b0;
            end else if (!tx_arblost) begin
              r_retry[r_cur] <= w_retry_nx;
              if (w_retry_lim) begin
                r_pend[r_cur] <= 1'b0;
                r_done_valid  <= 1'b1;
                r_done_mb     <= r_cur;
                r_done_ok     <= 1'b0;
              end
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wr_err     = r_wr_err;
  assign mb_pending = r_pend;
  assign tx_valid   = r_tx_valid;
  assign tx_id      = r_tx.id;
  assign tx_len     = r_tx.len;
  assign tx_data    = r_tx.data;
  assign done_valid = r_done_valid;
  assign done_mb    = r_done_mb;
  assign done_ok    = r_done_ok;

endmodule

// File: tb/tb_can_tx_sched.sv
// Directed bench for can_tx_sched (NUM_MB=4, MAX_RETRY=2).
module tb_can_tx_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_mb;
  logic [10:0] wr_id;
  logic [3:0]  wr_len;
  logic [63:0] wr_data;
  logic        wr_err;
  logic [3:0]  mb_pending;
  logic        tx_valid;
  logic        tx_ready;
  logic [10:0] tx_id;
  logic [3:0]  tx_len;
  logic [63:0] tx_data;
  logic        tx_done;
  logic        tx_ok;
  logic        tx_arblost;
  logic        done_valid;
  logic [1:0]  done_mb;
  logic        done_ok;
`ifdef CAN_TX_SCHED_ABORT_EN
  logic [3:0]  abort;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  can_tx_sched #(
    .NUM_MB    (4),
    .MAX_RETRY (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_mb      (wr_mb),
    .wr_id      (wr_id),
    .wr_len     (wr_len),
    .wr_data    (wr_data),
    .wr_err     (wr_err),
    .mb_pending (mb_pending),
`ifdef CAN_TX_SCHED_ABORT_EN
    .abort      (abort),
`endif
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_id      (tx_id),
    .tx_len     (tx_len),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .tx_ok      (tx_ok),
    .tx_arblost (tx_arblost),
    .done_valid (done_valid),
    .done_mb    (done_mb),
    .done_ok    (done_ok)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] mb, input logic [10:0] id, input logic [3:0] len,
                    input logic [63:0] data);
    wr_en = 1'b1; wr_mb = mb; wr_id = id; wr_len = len; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic expect_offer(input string tag, input logic [10:0] id, input logic [3:0] len,
                              input logic [63:0] data);
    tick();
    chk({tag, ".valid"}, 64'(tx_valid), 64'd1);
    chk({tag, ".id"},    64'(tx_id),    64'(id));
    chk({tag, ".len"},   64'(tx_len),   64'(len));
    chk({tag, ".data"},  tx_data,       data);
  endtask

  task automatic accept(input string tag);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk({tag, ".valid_drop"}, 64'(tx_valid), 64'd0);
  endtask

  task automatic finish_tx(input string tag, input logic ok, input logic arb,
                           input logic exp_v, input logic [1:0] exp_mb, input logic exp_ok);
    tx_done = 1'b1; tx_ok = ok; tx_arblost = arb;
    tick();
    tx_done = 1'b0; tx_ok = 1'b0; tx_arblost = 1'b0;
    chk({tag, ".done_valid"}, 64'(done_valid), 64'(exp_v));
    if (exp_v) begin
      chk({tag, ".done_mb"}, 64'(done_mb), 64'(exp_mb));
      chk({tag, ".done_ok"}, 64'(done_ok), 64'(exp_ok));
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".tx_valid"},   64'(tx_valid),   64'd0);
    chk({tag, ".done_valid"}, 64'(done_valid), 64'd0);
    chk({tag, ".wr_err"},     64'(wr_err),     64'd0);
    chk({tag, ".pending"},    64'(mb_pending), 64'd0);
    chk({tag, ".tx_id"},      64'(tx_id),      64'd0);
    chk({tag, ".tx_len"},     64'(tx_len),     64'd0);
    chk({tag, ".tx_data"},    tx_data,         64'd0);
    chk({tag, ".done_mb"},    64'(done_mb),    64'd0);
    chk({tag, ".done_ok"},    64'(done_ok),    64'd0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_mb = '0; wr_id = '0; wr_len = '0; wr_data = '0;
    tx_ready = 1'b0; tx_done = 1'b0; tx_ok = 1'b0; tx_arblost = 1'b0;
`ifdef CAN_TX_SCHED_ABORT_EN
    abort = '0;
`endif
    tick(); tick();
    chk_reset("rst");
    rst = 1'b0;
    tick();

    // Priority: mb0 (0x123, DLC 12 -> 8) and mb2 (0x045) queued behind mb3
    wr(2'd3, 11'h700, 4'd2, 64'h0000_0000_0000_BBAA);
    chk("p.pend_latency", 64'(mb_pending), 64'h8);
    expect_offer("p.mb3", 11'h700, 4'd2, 64'h0000_0000_0000_BBAA);
    accept("p.mb3");
    wr(2'd0, 11'h123, 4'd12, 64'h0706_0504_0302_0100);
    wr(2'd2, 11'h045, 4'd3, 64'h0000_0000_00CC_BBAA);
    chk("p.pend_both", 64'(mb_pending), 64'hD);
    finish_tx("p.mb3", 1'b1, 1'b0, 1'b1, 2'd3, 1'b1);
    chk("p.pend_after3", 64'(mb_pending), 64'h5);
    expect_offer("p.mb2", 11'h045, 4'd3, 64'h0000_0000_00CC_BBAA);
    chk("p.done_pulse", 64'(done_valid), 64'd0);
    accept("p.mb2");
    finish_tx("p.mb2", 1'b1, 1'b0, 1'b1, 2'd2, 1'b1);
    expect_offer("p.mb0", 11'h123, 4'd8, 64'h0706_0504_0302_0100);
    accept("p.mb0");
    finish_tx("p.mb0", 1'b1, 1'b0, 1'b1, 2'd0, 1'b1);
    chk("p.pend_empty", 64'(mb_pending), 64'h0);

    // Arbitration loss x3 does not consume retries; one error still retries
    wr(2'd1, 11'h2AA, 4'd1, 64'h0000_0000_0000_005A);
    for (int i = 0; i < 3; i++) begin
      expect_offer("a.offer", 11'h2AA, 4'd1, 64'h0000_0000_0000_005A);
      accept("a.offer");
      finish_tx("a.arblost", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    end
    expect_offer("a.offer4", 11'h2AA, 4'd1, 64'h0000_0000_0000_005A);
    accept("a.offer4");
    finish_tx("a.err1", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    expect_offer("a.offer5", 11'h2AA, 4'd1, 64'h0000_0000_0000_005A);
    accept("a.offer5");
    finish_tx("a.ok", 1'b1, 1'b0, 1'b1, 2'd1, 1'b1);

    // Error retry limit (2): second error drops mb3
    wr(2'd3, 11'h050, 4'd0, 64'h0);
    expect_offer("r.offer1", 11'h050, 4'd0, 64'h0);
    accept("r.offer1");
    finish_tx("r.err1", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    expect_offer("r.offer2", 11'h050, 4'd0, 64'h0);
    accept("r.offer2");
    finish_tx("r.err2", 1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
    chk("r.pend3_clear", 64'(mb_pending), 64'h0);
    tick();
    chk("r.no_offer", 64'(tx_valid), 64'd0);

    // Reload restarts the retry count from zero
    wr(2'd3, 11'h051, 4'd1, 64'h11);
    expect_offer("z.offer1", 11'h051, 4'd1, 64'h11);
    accept("z.offer1");
    finish_tx("z.err1", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    expect_offer("z.offer2", 11'h051, 4'd1, 64'h11);
    accept("z.offer2");
    finish_tx("z.err2", 1'b0, 1'b0, 1'b1, 2'd3, 1'b0);

    // Write to the in-flight mailbox is rejected
    wr(2'd0, 11'h111, 4'd8, 64'hDDDD_CCCC_BBBB_AAAA);
    expect_offer("w.offer", 11'h111, 4'd8, 64'hDDDD_CCCC_BBBB_AAAA);
    accept("w.offer");
    wr(2'd0, 11'h222, 4'd2, 64'h1234);
    chk("w.wr_err", 64'(wr_err), 64'd1);
    chk("w.tx_data", tx_data, 64'hDDDD_CCCC_BBBB_AAAA);
    tick();
    chk("w.wr_err_pulse", 64'(wr_err), 64'd0);
    finish_tx("w.done", 1'b1, 1'b0, 1'b1, 2'd0, 1'b1);
    chk("w.pend", 64'(mb_pending), 64'h0);

    // Equal identifiers: lower mailbox index first
    wr(2'd0, 11'h7FF, 4'd0, 64'h0);
    expect_offer("t.blk", 11'h7FF, 4'd0, 64'h0);
    accept("t.blk");
    wr(2'd3, 11'h300, 4'd1, 64'h33);
    wr(2'd1, 11'h300, 4'd1, 64'h11);
    finish_tx("t.blk", 1'b1, 1'b0, 1'b1, 2'd0, 1'b1);
    expect_offer("t.first", 11'h300, 4'd1, 64'h11);
    accept("t.first");
    finish_tx("t.first", 1'b1, 1'b0, 1'b1, 2'd1, 1'b1);
    expect_offer("t.second", 11'h300, 4'd1, 64'h33);
    accept("t.second");
    finish_tx("t.second", 1'b1, 1'b0, 1'b1, 2'd3, 1'b1);

`ifdef CAN_TX_SCHED_ABORT_EN
    // Abort queued mb1 while mb0 is in flight
    wr(2'd0, 11'h010, 4'd1, 64'h01);
    expect_offer("x.mb0", 11'h010, 4'd1, 64'h01);
    accept("x.mb0");
    wr(2'd1, 11'h020, 4'd1, 64'h02);
    abort = 4'b0010;
    tick();
    abort = '0;
    finish_tx("x.mb0", 1'b1, 1'b0, 1'b1, 2'd0, 1'b1);
    tick();
    chk("x.abort_valid", 64'(done_valid), 64'd1);
    chk("x.abort_mb", 64'(done_mb), 64'd1);
    chk("x.abort_ok", 64'(done_ok), 64'd0);
    chk("x.no_offer", 64'(tx_valid), 64'd0);
    tick();
    chk("x.pend", 64'(mb_pending), 64'h0);
    chk("x.no_offer2", 64'(tx_valid), 64'd0);
`endif

    // Reset during WAIT, then a stale tx_done
    wr(2'd2, 11'h033, 4'd4, 64'hCAFE_F00D);
    expect_offer("s.offer", 11'h033, 4'd4, 64'hCAFE_F00D);
    accept("s.offer");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    finish_tx("s.stale", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    chk_reset("s.post");
    tick();
    chk("s.idle", 64'(tx_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/can_tx_sched.md
# can_tx_sched

Transmit scheduler sitting between user-side transmit mailboxes and the single CAN frame transmitter that drives the bit-level engine. Holds `NUM_MB` frames, always offers the pending frame with the lowest identifier (CAN bus priority), and re-queues it after arbitration loss. Retries frames that fail on error up to a limit, and reports completion per mailbox.

## Interface
- `NUM_MB`, 4: number of mailboxes, 2..16.
- `MAX_RETRY`, 8: error retries before a frame is dropped, 1..255.
- `clk` in 1: system clock.
- `rst` in 1: reset. **Synchronous, active-high.**
- `wr_en` in 1: load mailbox strobe.
- `wr_mb` in `$clog2(NUM_MB)`: target mailbox.
- `wr_id` in 11: standard identifier.
- `wr_len` in 4: DLC. Values above 8 are saturated to 8 on load.
- `wr_data` in 64: payload, byte 0 in [7:0].
- `wr_err` out 1: one-cycle pulse; the write targeted a pending mailbox and was ignored.
- `mb_pending` out `NUM_MB`: mailbox holds an unsent frame.
- `abort` in `NUM_MB`: per-mailbox abort request. Present only with `CAN_TX_SCHED_ABORT_EN`.
- `tx_valid` out 1 / `tx_ready` in 1: frame offer handshake.
- `tx_id` out 11, `tx_len` out 4, `tx_data` out 64: offered frame. Stable while `tx_valid`=1.
- `tx_done` in 1: one-cycle pulse; the transmitter has finished the accepted frame.
- `tx_ok` in 1: frame acknowledged. Qualified by `tx_done`.
- `tx_arblost` in 1: arbitration lost. Qualified by `tx_done`.
- `done_valid` out 1: one-cycle completion pulse.
- `done_mb` out idx: completed mailbox.
- `done_ok` out 1: 1 = sent, 0 = dropped or aborted.

## Operation
- States: IDLE, OFFER, WAIT.
- **IDLE**
  - If any `mb_pending` bit is set, the scheduler latches the winner into the `tx_*` registers and goes to OFFER.
  - Winner = minimum `wr_id` among pending mailboxes. Ties go to the lowest mailbox index.
- **OFFER**
  - `tx_valid`=1.
  - On `tx_valid & tx_ready`, go to WAIT. `tx_valid` drops the following cycle.
  - There is no re-selection while in OFFER. A higher-priority write waits for the next IDLE pass.
- **WAIT**, on `tx_done`:
  - `tx_ok`=1: clear pending, clear the retry counter, pulse done with ok=1, go to IDLE.
  - `tx_arblost`=1 (and `tx_ok`=0): the retry counter is unchanged; go to IDLE and re-select.
  - Otherwise (error): increment the mailbox retry counter.
    - If the counter reaches `MAX_RETRY`, clear pending and pulse done with ok=0.
    - Either way, go to IDLE.
- **Writes**
  - A write to a non-pending mailbox stores the frame, zeroes its retry counter, and sets pending on the next edge.
  - A write to a pending mailbox, including the in-flight one, raises `wr_err` and leaves all state unchanged.
- Retry counters are 8 bit, one per mailbox.
- `tx_done` outside WAIT is ignored.

## Timing
- Reset values:
  - `tx_valid`=0, `done_valid`=0, `wr_err`=0, `mb_pending`=0, `tx_id/len/data`=0, `done_mb`=0, `done_ok`=0.
  - State = IDLE; all retry counters and abort flags are cleared.
- Reset asserted in OFFER or WAIT discards the in-flight frame with no done pulse. A `tx_done` arriving after reset is ignored.
- Latencies:
  - Write edge to `mb_pending` high: 1 cycle.
  - IDLE with pending to `tx_valid`: 1 cycle.
  - `tx_done` to `done_valid`: 1 cycle.
  - `tx_done` to the next `tx_valid`: 2 cycles minimum (WAIT→IDLE→OFFER).
- `wr_err` is asserted the cycle after the rejected write.
- At most one done pulse per cycle. A `tx_done` report has priority over abort reports.
- Arbitration loss can repeat without limit. Only errors count toward `MAX_RETRY`.

## Configuration
- **`CAN_TX_SCHED_ABORT_EN` defined:**
  - A rising `abort[i]` on a pending mailbox sets a sticky abort flag.
  - In IDLE, before selection, the lowest-indexed flagged mailbox is cleared and reported with ok=0. One mailbox is handled per IDLE cycle.
  - If that mailbox is in flight:
    - `tx_ok` still reports ok=1.
    - Arbitration loss or error reports ok=0 immediately, with no retry.
  - `abort` on a non-pending mailbox is ignored.
- **Undefined:** the `abort` port and the abort flags are absent.

## Structure
- `can_pkg`:
  - `can_frame_t` struct (id 11, len 4, data 64).
  - State enum.
  - `CAN_MAX_DLC` = 8.
- One sub-module, `can_prio_select`: purely combinational. Inputs are the pending mask and the ID array; outputs are the winner index and a valid flag. It is a tree of compare-min stages with ties resolved to the lower index.

## Test plan
- Load mb0 with id 0x123 and mb2 with id 0x045; `tx_ready`=1 → mb2 is offered first with `tx_id`=0x045, then mb0. Both are reported with ok=1.
- mb1 loaded; reply `tx_done` with `tx_arblost`=1 three times, then `tx_ok` → 4 offers, one done with ok=1, retry counter 0.
- `MAX_RETRY`=2, mb3 loaded, error replies (`tx_ok`=0, `tx_arblost`=0) → 2 offers, then `done_mb`=3 with `done_ok`=0 and `mb_pending[3]`=0.
- Write mb0 while it is in WAIT → `wr_err` pulses; `tx_data` is unchanged; the completion still reports the original frame.
- With `CAN_TX_SCHED_ABORT_EN`: abort a queued mb1 while mb0 is in flight → mb0 completes first, then the mb1 done has ok=0 and mb1 is never offered.
- Assert `rst` during WAIT, then issue `tx_done` → no done pulse; all outputs are at their reset values.
